mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port unified memory between the instruction-fetch port (IF) and the
//  load/store data port (D) of the multi-cycle RV32I core. Issues one memory access at a time.
//  Returns read data and a one-cycle ack to the winning requester. Sits between the CU/PC/ALU
//  datapath and the memory macro.
// PARAMETERS
//  MEM_AW   10  word-address width of memory (memory = 2**MEM_AW x 32b)
//  MEM_LAT  1   memory read latency in cycles, mem_en cycle -> mem_rdata valid; legal 1..15
// PORTS
//  clk        in   1       clock; all logic on posedge clk
//  rst        in   1       synchronous reset, active-high
//  if_req     in   1       IF read request; hold until if_ack
//  if_addr    in   32      IF byte address; bits [1:0] ignored
//  if_ack     out  1       one-cycle pulse; if_rdata valid this cycle
//  if_rdata   out  32      fetched instruction word (registered)
//  d_req      in   1       D request; hold until d_ack
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   32      D byte address; bits [1:0] ignored
//  d_wdata    in   32      store data
//  d_be       in   4       store byte enables
//  d_ack      out  1       one-cycle pulse; d_rdata valid this cycle on loads
//  d_rdata    out  32      load word (registered)
//  mem_en     out  1       memory access strobe, one cycle per access
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  MEM_AW  word address = addr[MEM_AW+1:2] of the winner
//  mem_wdata  out  32      write data
//  mem_be     out  4       byte enables; 4'hF on reads
//  mem_rdata  in   32      read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; latency counter 0; last-grant = D. Reset mid-access aborts
//    it: no ack is issued and mem_en drops the next cycle. A write already strobed is not undone.
//  - Interface rules: request fields must stay stable while req=1 until ack. Requester deasserts
//    req, or presents a new transaction, in the cycle after ack.
//  - FSM IDLE -> ISSUE -> WAIT -> ACK -> IDLE:
//    - IDLE: if any req, pick the winner. Register owner and the mem_* fields, then go to ISSUE.
//    - ISSUE: mem_en=1 for exactly this cycle. Write: go to ACK. Read: load counter=MEM_LAT, go to WAIT.
//    - WAIT: decrement counter. When it reaches 0, capture mem_rdata into the owner's rdata and go to ACK.
//    - ACK: pulse the owner's ack for 1 cycle, then return to IDLE. The other port's ack stays 0.
//  - Latency from req sampled in IDLE (cycle 0):
//    - write: ack at cycle 2
//    - read: ack at cycle MEM_LAT+2
//    - back-to-back accesses: next IDLE sample is the cycle after ACK
//  - A request arriving during ISSUE/WAIT/ACK waits, never dropped. Never more than one access outstanding.
//  - IF requests with if_addr-derived mem_we=0 and mem_be=4'hF always. if_rdata/d_rdata hold their
//    value until the next read for that port.
//  - Simultaneous if_req & d_req in IDLE: arbitration per CONFIGURATION. Single req always wins.
//  - Address bits above MEM_AW+1 ignored (wrap-around within memory).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN
//  - Defined: on a tie, grant the port not granted last. last-grant is updated on every grant and
//    reset to D, so the first tie goes to IF.
//  - Undefined: fixed priority, D always wins ties (a stalled load/store must retire before the next
//    fetch); last-grant logic absent.
// STRUCTURE
//  - Shared package riscv_pkg:
//    - arb_state_t enum {IDLE, ISSUE, WAIT, ACK}
//    - OWNER_IF=1'b0, OWNER_D=1'b1
//    - MEM_LAT_W=4 counter width
//  - Sub-module arb_pick: combinational winner select from (if_req, d_req, last_grant). Holds the
//    ARB_ROUND_ROBIN_EN variant.
// TESTING
//  1. MEM_LAT=1, IF read 0x0000_0010, mem word 4 = 0x0000_0013 -> mem_en cycle 1, mem_addr=4,
//     if_ack + if_rdata=0x13 cycle 3.
//  2. D store addr 0x20, wdata 0xDEADBEEF, be 4'b0011 -> mem_en&mem_we cycle 1, mem_be=0011,
//     d_ack cycle 2, if_ack never.
//  3. if_req & d_req same cycle, macro undefined -> D served first, IF acked after D.
//     Repeat 4 ties: D always first.
//  4. ARB_ROUND_ROBIN_EN, 4 consecutive ties -> grant order IF, D, IF, D.
//  5. MEM_LAT=3, rst pulsed during WAIT -> no ack, all outputs 0 next cycle.
//     New if_req then acked at cycle 5 after sample.
//  6. d_req held during an IF access in WAIT -> D granted in the IDLE cycle right after IF ack.
//     Exactly one mem_en per access.

Source files
------------

// File: rtl/riscv_pkg.sv
// Types and constants shared by the RV32I core memory subsystem.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_D   = 1'b1;
  localparam int   MEM_LAT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-macro signals of the unified-memory arbiter.
interface mem_arbiter_if #(
  parameter int MEM_AW = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select between fetch and load/store requests.
// ARB_ROUND_ROBIN_EN: ties alternate on last_grant; otherwise D wins ties.
module arb_pick
  import riscv_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant
);

  always_comb begin
    grant_valid = if_req | d_req;
    grant       = OWNER_D;
    if (if_req && !d_req) begin
      grant = OWNER_IF;
    end
`ifdef ARB_ROUND_ROBIN_EN
    else if (if_req && d_req) begin
      grant = (last_grant == OWNER_D) ? OWNER_IF : OWNER_D;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and load/store.
// Optional round-robin tie-breaking via macro ARB_ROUND_ROBIN_EN.
//   state | meaning
//   IDLE  | sample requests, latch winner and its access fields
//   ISSUE | mem_en strobe for one cycle
//   WAIT  | count down read latency, capture mem_rdata on terminal count
//   ACK   | one-cycle ack to the owner
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int MEM_AW  = 10,
  parameter int MEM_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arb_state_t           state, state_nxt;
  logic                 owner;
  logic                 grant_valid, grant;
  logic [MEM_LAT_W-1:0] cnt;
  logic                 mem_we_q;
  logic [MEM_AW-1:0]    mem_addr_q;
  logic [31:0]          mem_wdata_q, if_rdata_q, d_rdata_q;
  logic [3:0]           mem_be_q;
  logic                 unused_addr_bits;

  // Byte-offset and out-of-range address bits are dropped: accesses wrap in memory.
  assign unused_addr_bits = ^{bus.if_addr[31:MEM_AW+2], bus.if_addr[1:0],
                              bus.d_addr[31:MEM_AW+2], bus.d_addr[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  arb_pick u_pick (
    .if_req      (bus.if_req),
    .d_req       (bus.d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_ff @(posedge clk) begin
    if (rst)                              last_grant <= OWNER_D;
    else if (state == IDLE && grant_valid) last_grant <= grant;
  end
`else
  arb_pick u_pick (
    .if_req      (bus.if_req),
    .d_req       (bus.d_req),
    .grant_valid (grant_valid),
    .grant       (grant)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus.mem_en = 1'b0;
    bus.if_ack = 1'b0;
    bus.d_ack  = 1'b0;
    case (state)
      IDLE:  if (grant_valid) state_nxt = ISSUE;
      ISSUE: begin
        bus.mem_en = 1'b1;
        state_nxt  = mem_we_q ? ACK : WAIT;
      end
      WAIT:  if (cnt == MEM_LAT_W'(1)) state_nxt = ACK;
      ACK: begin
        bus.if_ack = (owner == OWNER_IF);
        bus.d_ack  = (owner == OWNER_D);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWNER_IF;
      cnt         <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          owner <= grant;
          if (grant == OWNER_D) begin
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr[MEM_AW+1:2];
            mem_wdata_q <= bus.d_wdata;
            mem_be_q    <= bus.d_we ? bus.d_be : 4'hF;
          end else begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr[MEM_AW+1:2];
            mem_wdata_q <= '0;
            mem_be_q    <= 4'hF;
          end
        end
        ISSUE: cnt <= MEM_LAT_W'(MEM_LAT);
        WAIT: begin
          cnt <= cnt - MEM_LAT_W'(1);
          if (cnt == MEM_LAT_W'(1)) begin
            if (owner == OWNER_IF) if_rdata_q <= bus.mem_rdata;
            else                   d_rdata_q  <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_arbiter;
  import riscv_pkg::*;

  localparam int MEM_AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.MEM_AW(MEM_AW)) bus1 ();
  mem_arbiter_if #(.MEM_AW(MEM_AW)) bus3 ();

  mem_arbiter #(.MEM_AW(MEM_AW), .MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  mem_arbiter #(.MEM_AW(MEM_AW), .MEM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  // Memory content: word 4 holds 0x13, every other word is 0xC0DE0000 | word address.
  function automatic logic [31:0] mem_word(input logic [MEM_AW-1:0] a);
    return (a == 10'd4) ? 32'h0000_0013 : {16'hC0DE, 6'd0, a};
  endfunction

  logic        p1_v = 1'b0;
  logic [31:0] p1_d = '0;
  logic [2:0]  p3_v = '0;
  logic [31:0] p3_d [3];

  always @(posedge clk) begin
    p1_v    <= bus1.mem_en & ~bus1.mem_we;
    p1_d    <= mem_word(bus1.mem_addr);
    p3_v    <= {p3_v[1:0], bus3.mem_en & ~bus3.mem_we};
    p3_d[0] <= mem_word(bus3.mem_addr);
    p3_d[1] <= p3_d[0];
    p3_d[2] <= p3_d[1];
  end

  // Read data is only valid in the exact latency cycle; anything else reads a poison word.
  assign bus1.mem_rdata = p1_v    ? p1_d    : 32'hBAD0_BAD0;
  assign bus3.mem_rdata = p3_v[2] ? p3_d[2] : 32'hBAD0_BAD0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic watch1(input bit want_d, output int ack_c, output int en_c, output int n_en,
                        output int n_oth, output logic [MEM_AW-1:0] a, output logic w,
                        output logic [3:0] be, output logic [31:0] wd);
    ack_c = -1; en_c = -1; n_en = 0; n_oth = 0; a = '0; w = 1'b0; be = '0; wd = '0;
    for (int i = 1; i <= 20; i++) begin
      next_cyc();
      if (bus1.mem_en) begin
        n_en++; en_c = i; a = bus1.mem_addr; w = bus1.mem_we; be = bus1.mem_be; wd = bus1.mem_wdata;
      end
      if (want_d ? bus1.if_ack : bus1.d_ack) n_oth++;
      if (want_d ? bus1.d_ack : bus1.if_ack) begin
        ack_c = i;
        break;
      end
    end
  endtask

  task automatic watch3(output int ack_c, output int n_en);
    ack_c = -1; n_en = 0;
    for (int i = 1; i <= 20; i++) begin
      next_cyc();
      if (bus3.mem_en) n_en++;
      if (bus3.if_ack) begin
        ack_c = i;
        break;
      end
    end
  endtask

  task automatic tie_pair(output logic first, output int c1, output int c2);
    int n;
    n = 0; first = 1'b0; c1 = -1; c2 = -1;
    bus1.if_addr = 32'h10; bus1.d_addr = 32'h30; bus1.d_we = 1'b0;
    bus1.if_req = 1'b1; bus1.d_req = 1'b1;
    for (int i = 1; i <= 20 && n < 2; i++) begin
      next_cyc();
      if (bus1.if_ack) begin
        if (n == 0) begin first = OWNER_IF; c1 = i; end else c2 = i;
        n++; bus1.if_req = 1'b0;
      end
      if (bus1.d_ack) begin
        if (n == 0) begin first = OWNER_D; c1 = i; end else c2 = i;
        n++; bus1.d_req = 1'b0;
      end
    end
    bus1.if_req = 1'b0; bus1.d_req = 1'b0;
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ack_c, en_c, n_en, n_oth, c1, c2, n, last_c;
    logic [MEM_AW-1:0] a;
    logic w, first, w6;
    logic [3:0] be, seq, exp_seq;
    logic [31:0] wd;
    logic [10:0] en_mask;
    logic [MEM_AW-1:0] a6;
    int ia, da;
    logic exp_first;

`ifdef ARB_ROUND_ROBIN_EN
    exp_first = OWNER_IF;
    exp_seq   = 4'b1010;
`else
    exp_first = OWNER_D;
    exp_seq   = 4'b1111;
`endif

    {bus1.if_req, bus1.d_req, bus1.d_we} = '0;
    {bus1.if_addr, bus1.d_addr, bus1.d_wdata, bus1.d_be} = '0;
    {bus3.if_req, bus3.d_req, bus3.d_we} = '0;
    {bus3.if_addr, bus3.d_addr, bus3.d_wdata, bus3.d_be} = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) next_cyc();
    chk("rst_ctrl", {28'd0, bus1.if_ack, bus1.d_ack, bus1.mem_en, bus1.mem_we}, 32'd0);
    chk("rst_addr_be", {18'd0, bus1.mem_be, bus1.mem_addr}, 32'd0);
    chk("rst_wdata", bus1.mem_wdata, 32'd0);
    chk("rst_rdata", bus1.if_rdata | bus1.d_rdata, 32'd0);
    rst = 1'b0;
    next_cyc();

    // IF read of word 4
    bus1.if_addr = 32'h0000_0010; bus1.if_req = 1'b1;
    watch1(1'b0, ack_c, en_c, n_en, n_oth, a, w, be, wd);
    bus1.if_req = 1'b0;
    chk("t1_en_cycle", en_c, 1);
    chk("t1_mem_addr", a, 32'd4);
    chk("t1_we_be", {w, be}, {1'b0, 4'hF});
    chk("t1_ack_cycle", ack_c, 3);
    chk("t1_if_rdata", bus1.if_rdata, 32'h13);
    chk("t1_en_count", n_en, 1);
    next_cyc();

    // D store
    bus1.d_addr = 32'h20; bus1.d_wdata = 32'hDEAD_BEEF; bus1.d_be = 4'b0011;
    bus1.d_we = 1'b1; bus1.d_req = 1'b1;
    watch1(1'b1, ack_c, en_c, n_en, n_oth, a, w, be, wd);
    bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    chk("t2_en_cycle", en_c, 1);
    chk("t2_we_be", {w, be}, {1'b1, 4'b0011});
    chk("t2_mem_addr", a, 32'd8);
    chk("t2_wdata", wd, 32'hDEAD_BEEF);
    chk("t2_ack_cycle", ack_c, 2);
    chk("t2_no_if_ack", n_oth, 0);
    next_cyc();

    // D load, IF read data must hold
    bus1.d_addr = 32'h30; bus1.d_be = 4'b0001; bus1.d_req = 1'b1;
    watch1(1'b1, ack_c, en_c, n_en, n_oth, a, w, be, wd);
    bus1.d_req = 1'b0;
    chk("ld_ack_cycle", ack_c, 3);
    chk("ld_be_read", {w, be}, {1'b0, 4'hF});
    chk("ld_d_rdata", bus1.d_rdata, 32'hC0DE_000C);
    chk("ld_if_rdata_hold", bus1.if_rdata, 32'h13);
    next_cyc();

    // Address wrap: 0x1010 maps to word 4 in a 1K-word memory
    bus1.if_addr = 32'h0000_1010; bus1.if_req = 1'b1;
    watch1(1'b0, ack_c, en_c, n_en, n_oth, a, w, be, wd);
    bus1.if_req = 1'b0;
    chk("wrap_mem_addr", a, 32'd4);
    chk("wrap_if_rdata", bus1.if_rdata, 32'h13);
    next_cyc();

    // D request raised while IF read is in WAIT
    en_mask = '0; ia = -1; da = -1; a6 = '0; w6 = 1'b0;
    bus1.if_addr = 32'h10; bus1.if_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      next_cyc();
      if (bus1.mem_en) begin
        en_mask[i] = 1'b1;
        if (i > 1) begin a6 = bus1.mem_addr; w6 = bus1.mem_we; end
      end
      if (i == 2) begin
        bus1.d_addr = 32'h44; bus1.d_wdata = 32'h1234_5678; bus1.d_be = 4'hF;
        bus1.d_we = 1'b1; bus1.d_req = 1'b1;
      end
      if (bus1.if_ack) begin ia = i; bus1.if_req = 1'b0; end
      if (bus1.d_ack)  begin da = i; bus1.d_req = 1'b0; end
    end
    bus1.d_we = 1'b0;
    chk("t6_if_ack_cycle", ia, 3);
    chk("t6_d_ack_cycle", da, 6);
    chk("t6_en_mask", {21'd0, en_mask}, 32'h022);
    chk("t6_d_addr_we", {w6, a6}, {1'b1, 10'h011});

    // Ties as pairs, from reset
    rst = 1'b1; next_cyc(); rst = 1'b0; next_cyc();
    for (int k = 0; k < 4; k++) begin
      tie_pair(first, c1, c2);
      chk($sformatf("tie%0d_first", k), first, exp_first);
      chk($sformatf("tie%0d_first_cyc", k), c1, 3);
      chk($sformatf("tie%0d_second_cyc", k), c2, 7);
    end

    // Both ports requesting continuously: every IDLE is a tie
    seq = '0; n = 0; last_c = -1;
    bus1.if_addr = 32'h10; bus1.d_addr = 32'h30; bus1.d_we = 1'b0;
    bus1.if_req = 1'b1; bus1.d_req = 1'b1;
    for (int i = 1; i <= 40 && n < 4; i++) begin
      next_cyc();
      if (bus1.if_ack) begin seq[n[1:0]] = OWNER_IF; n++; last_c = i; end
      if (bus1.d_ack)  begin seq[n[1:0]] = OWNER_D;  n++; last_c = i; end
    end
    bus1.if_req = 1'b0; bus1.d_req = 1'b0;
    chk("stream_count", n, 4);
    chk("stream_order", seq, exp_seq);
    chk("stream_last_cyc", last_c, 15);
    next_cyc();

    // MEM_LAT=3: full read, then reset during WAIT
    bus3.if_addr = 32'h40; bus3.if_req = 1'b1;
    watch3(ack_c, n_en);
    bus3.if_req = 1'b0;
    chk("t5_lat3_ack_cycle", ack_c, 5);
    chk("t5_lat3_rdata", bus3.if_rdata, 32'hC0DE_0010);
    next_cyc();
    bus3.if_addr = 32'h08; bus3.if_req = 1'b1;
    next_cyc();
    chk("t5_issue_en", bus3.mem_en, 1'b1);
    next_cyc();
    rst = 1'b1;
    next_cyc();
    chk("t5_rst_ctrl", {28'd0, bus3.if_ack, bus3.d_ack, bus3.mem_en, bus3.mem_we}, 32'd0);
    chk("t5_rst_addr_be", {18'd0, bus3.mem_be, bus3.mem_addr}, 32'd0);
    chk("t5_rst_rdata", bus3.if_rdata, 32'd0);
    rst = 1'b0;
    bus3.if_addr = 32'h04;
    watch3(ack_c, n_en);
    bus3.if_req = 1'b0;
    chk("t5_new_ack_cycle", ack_c, 5);
    chk("t5_new_rdata", bus3.if_rdata, 32'hC0DE_0001);
    chk("t5_new_en_count", n_en, 1);
    next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
